// File: rtl/net_pkg.sv
// Shared constants for the TX network path and the packet arbiter state encoding.
package net_pkg;

    localparam int C_MIN_PKT_BYTES = 46;
    localparam int C_MAX_PKT_BYTES = 1500;
    localparam int C_ETH_HDR_BYTES = 14;

    // Plain vector encoding keeps the state visible as raw bits in older tools and dumps.
    typedef logic [2:0] arb_state_t;

    localparam arb_state_t S_IDLE      = 3'd0;
    localparam arb_state_t S_GRANT     = 3'd1;
    localparam arb_state_t S_STREAM    = 3'd2;
    localparam arb_state_t S_FLUSH     = 3'd3;
    localparam arb_state_t S_WAIT_DONE = 3'd4;
    localparam arb_state_t S_GAP       = 3'd5;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr (wrapping) wins.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);

    localparam int IW = $clog2(N);

    int pos;

    // NOTE: every output gets a default before the loop so no path can infer a latch.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 1; k <= N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/tx_pkt_arb.sv
// Round-robin arbiter sharing the TX packet builder byte stream between packet sources,
// holding the grant for a whole packet and guarding against overlong or gapped streams.
module tx_pkt_arb
    import net_pkg::*;
#(
    parameter int P_NUM_REQ   = 2,
    parameter int P_MAX_BYTES = C_MAX_PKT_BYTES
) (
    input  logic                    tx_clk,
    input  logic                    tx_rst_n,
    input  logic [P_NUM_REQ-1:0]    req_vld,
    input  logic [48*P_NUM_REQ-1:0] req_dst_mac,
    input  logic [16*P_NUM_REQ-1:0] req_pkt_type,
    input  logic [P_NUM_REQ-1:0]    req_byte_vld,
    input  logic [P_NUM_REQ-1:0]    req_byte_last,
    input  logic [8*P_NUM_REQ-1:0]  req_byte,
    output logic [P_NUM_REQ-1:0]    req_byte_rdy,
    output logic [P_NUM_REQ-1:0]    req_gnt,
    output logic [P_NUM_REQ-1:0]    req_done,
    output logic [47:0]             m_dst_mac,
    output logic [15:0]             m_pkt_type,
    output logic                    m_byte_vld,
    input  logic                    m_byte_rdy,
    output logic [7:0]              m_byte,
    input  logic                    pkt_vld_mon,
    input  logic                    pkt_rdy_mon,
    output logic                    busy,
    output logic                    err_overrun,
    output logic                    err_underrun
);

    localparam int IW = $clog2(P_NUM_REQ);
    localparam int CW = $clog2(P_MAX_BYTES + 1);

    arb_state_t           state;
    logic [IW-1:0]        gnt_idx;
    logic [IW-1:0]        rr_ptr;
    logic [CW-1:0]        byte_cnt;
    logic                 done_seen;

    logic [P_NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]        arb_idx;
    logic                 arb_found;

    logic [47:0]          dst_arr  [P_NUM_REQ];
    logic [15:0]          type_arr [P_NUM_REQ];
    logic [7:0]           byte_arr [P_NUM_REQ];

    logic                 sel_vld;
    logic                 sel_last;
    logic                 accept;
    logic                 pkt_done;
    logic                 at_max;

    rr_arbiter #(.N(P_NUM_REQ)) u_rr (
        .req   (req_vld),
        .ptr   (rr_ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .found (arb_found)
    );

    always_comb begin
        for (int i = 0; i < P_NUM_REQ; i++) begin
            dst_arr[i]  = req_dst_mac[i*48 +: 48];
            type_arr[i] = req_pkt_type[i*16 +: 16];
            byte_arr[i] = req_byte[i*8 +: 8];
        end
    end

    assign sel_vld  = req_byte_vld[gnt_idx];
    assign sel_last = req_byte_last[gnt_idx];
    assign pkt_done = pkt_vld_mon & pkt_rdy_mon;
    assign at_max   = (byte_cnt == CW'(P_MAX_BYTES - 1));
    assign busy     = (state != S_IDLE);

    // Only S_STREAM reaches the builder; flushed bytes are swallowed here.
    assign m_byte_vld = (state == S_STREAM) & sel_vld;
    assign m_byte     = (state == S_STREAM) ? byte_arr[gnt_idx] : 8'h00;

    always_comb begin
        req_byte_rdy = '0;
        accept       = 1'b0;
        case (state)
            S_STREAM: begin
                req_byte_rdy = req_gnt & {P_NUM_REQ{m_byte_rdy}};
                accept       = sel_vld & m_byte_rdy;
            end
            S_FLUSH: begin
                req_byte_rdy = req_gnt;
                accept       = sel_vld;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge tx_clk) begin
        if (!tx_rst_n) begin
            state        <= S_IDLE;
            gnt_idx      <= '0;
            rr_ptr       <= IW'(P_NUM_REQ - 1);
            byte_cnt     <= '0;
            done_seen    <= 1'b0;
            req_gnt      <= '0;
            req_done     <= '0;
            m_dst_mac    <= '0;
            m_pkt_type   <= '0;
            err_overrun  <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            req_done     <= '0;
            err_overrun  <= 1'b0;
            err_underrun <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arb_found) begin
                        req_gnt    <= arb_gnt;
                        gnt_idx    <= arb_idx;
                        rr_ptr     <= arb_idx;
                        m_dst_mac  <= dst_arr[arb_idx];
                        m_pkt_type <= type_arr[arb_idx];
                        state      <= S_GRANT;
                    end
                end
                S_GRANT: state <= S_STREAM;
                S_STREAM: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + CW'(1);
                        // Last wins over overrun when it lands on the final allowed byte.
                        if (sel_last) begin
                            state <= S_WAIT_DONE;
                        end else if (at_max) begin
                            err_overrun <= 1'b1;
                            state       <= S_FLUSH;
                        end
                    end else if (!sel_vld && byte_cnt != '0) begin
                        err_underrun <= 1'b1;
                        state        <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    // The builder may hand off the short packet before the source finishes.
                    if (pkt_done) done_seen <= 1'b1;
                    if (accept && sel_last) state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (pkt_done || done_seen) begin
                        req_done  <= req_gnt;
                        req_gnt   <= '0;
                        byte_cnt  <= '0;
                        done_seen <= 1'b0;
                        state     <= S_GAP;
                    end
                end
                S_GAP:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_pkt_arb.sv
// Scoreboard bench for tx_pkt_arb: random/directed sources, a builder model and a decoupled monitor.
module tb_tx_pkt_arb;
    import net_pkg::*;

    localparam int N    = 2;
    localparam int PMAX = C_MAX_PKT_BYTES;

    logic              tx_clk = 1'b0;
    logic              tx_rst_n;
    logic [N-1:0]      req_vld, req_byte_vld, req_byte_last;
    logic [48*N-1:0]   req_dst_mac;
    logic [16*N-1:0]   req_pkt_type;
    logic [8*N-1:0]    req_byte;
    logic [N-1:0]      req_byte_rdy, req_gnt, req_done;
    logic [47:0]       m_dst_mac;
    logic [15:0]       m_pkt_type;
    logic              m_byte_vld, m_byte_rdy;
    logic [7:0]        m_byte;
    logic              pkt_vld_mon, pkt_rdy_mon;
    logic              busy, err_overrun, err_underrun;

    tx_pkt_arb #(.P_NUM_REQ(N), .P_MAX_BYTES(PMAX)) dut (
        .tx_clk(tx_clk), .tx_rst_n(tx_rst_n), .req_vld(req_vld), .req_dst_mac(req_dst_mac),
        .req_pkt_type(req_pkt_type), .req_byte_vld(req_byte_vld), .req_byte_last(req_byte_last),
        .req_byte(req_byte), .req_byte_rdy(req_byte_rdy), .req_gnt(req_gnt), .req_done(req_done),
        .m_dst_mac(m_dst_mac), .m_pkt_type(m_pkt_type), .m_byte_vld(m_byte_vld),
        .m_byte_rdy(m_byte_rdy), .m_byte(m_byte), .pkt_vld_mon(pkt_vld_mon),
        .pkt_rdy_mon(pkt_rdy_mon), .busy(busy), .err_overrun(err_overrun),
        .err_underrun(err_underrun)
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct {
        logic [47:0] dst;
        logic [15:0] typ;
        int          seed;
        int          fwd;
        bit          ovr;
        bit          und;
    } exp_pkt_t;

    exp_pkt_t exp_q [N][$];

    int total = 0;
    int bad   = 0;

    task automatic check(input bit ok, input string name, input string info);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: %s", name, info);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Reference rule: first pending requester after the previous winner, wrapping.
    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int frame_bytes(input int n);
        return ((n < C_MIN_PKT_BYTES) ? C_MIN_PKT_BYTES : n) + C_ETH_HDR_BYTES;
    endfunction

    // Source and builder models
    bit          rst_hold;
    bit          r_active [N];
    int          r_len [N], r_gap_at [N], r_gap_left [N], r_delay [N], r_sent [N], r_seed [N];
    logic [47:0] r_dst [N];
    logic [15:0] r_typ [N];
    int          b_cnt, b_hold, b_hold_next, b_last_bytes;
    bit          b_vld;

    task automatic clear_models();
        for (int i = 0; i < N; i++) begin
            r_active[i] = 1'b0; r_len[i] = 0; r_gap_at[i] = 0; r_gap_left[i] = 0;
            r_delay[i] = 0; r_sent[i] = 0; r_seed[i] = 0; r_dst[i] = '0; r_typ[i] = '0;
        end
        b_cnt = 0; b_hold = 0; b_hold_next = 0; b_vld = 1'b0;
    endtask

    task automatic start_pkt(input int i, input int len, input int gap_at, input int delay);
        exp_pkt_t e;
        r_active[i]   = 1'b1;
        r_len[i]      = len;
        r_gap_at[i]   = gap_at;
        r_gap_left[i] = (gap_at > 0) ? int'($urandom_range(1, 3)) : 0;
        r_delay[i]    = delay;
        r_sent[i]     = 0;
        r_seed[i]     = int'($urandom_range(0, 255));
        r_dst[i]      = {16'($urandom()), $urandom()};
        r_typ[i]      = 16'($urandom());
        e.dst  = r_dst[i];
        e.typ  = r_typ[i];
        e.seed = r_seed[i];
        e.und  = (gap_at > 0);
        e.ovr  = (gap_at == 0) && (len > PMAX);
        e.fwd  = (gap_at > 0) ? gap_at : ((len > PMAX) ? PMAX : len);
        exp_q[i].push_back(e);
    endtask

    task automatic drive();
        tx_rst_n = !rst_hold;
        for (int i = 0; i < N; i++) begin
            req_vld[i]             = r_active[i];
            req_dst_mac[i*48 +: 48] = r_dst[i];
            req_pkt_type[i*16 +: 16] = r_typ[i];
            req_byte_vld[i]        = r_active[i] && (r_sent[i] < r_len[i]) && (r_delay[i] == 0)
                                     && !(r_gap_left[i] > 0 && r_sent[i] == r_gap_at[i]);
            req_byte[i*8 +: 8]     = 8'(r_seed[i] + r_sent[i]);
            req_byte_last[i]       = (r_sent[i] == r_len[i] - 1);
        end
        m_byte_rdy  = !b_vld && ($urandom_range(0, 3) != 0);
        pkt_vld_mon = b_vld;
        pkt_rdy_mon = (b_hold == 0) && ($urandom_range(0, 1) == 1);
    endtask

    task automatic sample();
        for (int i = 0; i < N; i++) begin
            if (req_byte_vld[i] && req_byte_rdy[i]) r_sent[i]++;
            else if (r_active[i] && r_delay[i] > 0) r_delay[i]--;
            else if (r_active[i] && r_gap_left[i] > 0 && r_sent[i] == r_gap_at[i]) r_gap_left[i]--;
            if (req_done[i]) r_active[i] = 1'b0;
        end
        // Builder closes a packet when the byte stream drops after at least one byte.
        if (b_vld) begin
            if (pkt_vld_mon && pkt_rdy_mon) b_vld = 1'b0;
            else if (b_hold > 0) b_hold--;
        end else if (m_byte_vld && m_byte_rdy) begin
            b_cnt++;
        end else if (!m_byte_vld && b_cnt > 0) begin
            b_last_bytes = frame_bytes(b_cnt);
            b_cnt        = 0;
            b_vld        = 1'b1;
            b_hold       = b_hold_next;
            b_hold_next  = 0;
        end
    endtask

    task automatic step();
        @(negedge tx_clk);
        drive();
        #3;
        sample();
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((r_active[0] || r_active[1] || b_vld || b_cnt != 0) && n < bound) begin
            step();
            n++;
        end
        check(n < bound, "idle_timeout", $sformatf("cycles=%0d limit=%0d", n, bound));
        repeat (2) step();
    endtask

    // Monitor: pops the expected packet on each grant and checks everything the DUT presents.
    initial begin
        int          last_w = N - 1;
        bit          cur_v = 1'b0;
        int          cur = 0, fwd = 0, w;
        bit          s_ovr = 1'b0, s_und = 1'b0, prev_rst = 1'b0, grant_edge;
        exp_pkt_t    ce;
        logic [N-1:0] prev_gnt = '0, prev_vld = '0;
        logic [47:0] prev_mac = '0;
        logic [15:0] prev_typ = '0;
        forever begin
            @(negedge tx_clk);
            #3;
            if (!tx_rst_n) begin
                cur_v  = 1'b0;
                last_w = N - 1;
                for (int i = 0; i < N; i++) exp_q[i].delete();
            end
            if (prev_rst) begin
                check(req_gnt == '0 && req_done == '0 && !busy, "rst_ctrl",
                      $sformatf("gnt=%b done=%b busy=%b want 0", req_gnt, req_done, busy));
                check(m_dst_mac == '0 && m_pkt_type == '0, "rst_hdr",
                      $sformatf("mac=%h type=%h want 0", m_dst_mac, m_pkt_type));
                check(!m_byte_vld && m_byte == 8'h00 && req_byte_rdy == '0, "rst_stream",
                      $sformatf("vld=%b byte=%h rdy=%b want 0", m_byte_vld, m_byte, req_byte_rdy));
                check(!err_overrun && !err_underrun, "rst_err",
                      $sformatf("ovr=%b und=%b want 0", err_overrun, err_underrun));
            end else if (tx_rst_n) begin
                grant_edge = (prev_gnt == '0) && (req_gnt != '0);
                if (m_dst_mac != prev_mac || m_pkt_type != prev_typ)
                    check(grant_edge, "hdr_stable", $sformatf("mac %h->%h outside grant", prev_mac, m_dst_mac));
                if (grant_edge) begin
                    w = rr_pick(prev_vld, last_w);
                    check(w >= 0 && req_gnt == onehot(w), "gnt_order",
                          $sformatf("got %b want idx %0d (vld %b last %0d)", req_gnt, w, prev_vld, last_w));
                    if (w >= 0) begin
                        check(exp_q[w].size() != 0, "gnt_pending", $sformatf("grant to idle req %0d", w));
                        if (exp_q[w].size() != 0) begin
                            ce    = exp_q[w].pop_front();
                            cur_v = 1'b1;
                            cur   = w;
                            fwd   = 0;
                            s_ovr = 1'b0;
                            s_und = 1'b0;
                            check(m_dst_mac == ce.dst && m_pkt_type == ce.typ, "hdr",
                                  $sformatf("got %h/%h want %h/%h", m_dst_mac, m_pkt_type, ce.dst, ce.typ));
                        end
                        last_w = w;
                    end
                end
                if (cur_v && req_done == '0)
                    check(req_gnt == onehot(cur) && busy, "gnt_hold",
                          $sformatf("gnt=%b busy=%b want idx %0d busy 1", req_gnt, busy, cur));
                if (m_byte_vld && m_byte_rdy) begin
                    check(cur_v && fwd < ce.fwd && m_byte == 8'(ce.seed + fwd), "byte",
                          $sformatf("n=%0d got %h want %h (limit %0d)", fwd, m_byte, 8'(ce.seed + fwd), ce.fwd));
                    fwd++;
                end
                if (err_overrun) begin
                    check(cur_v && ce.ovr && !s_ovr, "err_overrun", $sformatf("unexpected pulse at n=%0d", fwd));
                    s_ovr = 1'b1;
                end
                if (err_underrun) begin
                    check(cur_v && ce.und && !s_und, "err_underrun", $sformatf("unexpected pulse at n=%0d", fwd));
                    s_und = 1'b1;
                end
                if (req_done != '0) begin
                    check(cur_v && req_done == onehot(cur), "done_idx",
                          $sformatf("got %b want idx %0d", req_done, cur));
                    if (cur_v) begin
                        check(fwd == ce.fwd, "fwd_count", $sformatf("got %0d want %0d", fwd, ce.fwd));
                        check(s_ovr == ce.ovr && s_und == ce.und, "err_flags",
                              $sformatf("ovr/und got %b%b want %b%b", s_ovr, s_und, ce.ovr, ce.und));
                        check(b_last_bytes == frame_bytes(ce.fwd), "builder_bytes",
                              $sformatf("got %0d want %0d", b_last_bytes, frame_bytes(ce.fwd)));
                    end
                    cur_v = 1'b0;
                end
            end
            prev_gnt = req_gnt;
            prev_vld = req_vld;
            prev_mac = m_dst_mac;
            prev_typ = m_pkt_type;
            prev_rst = !tx_rst_n;
        end
    end

    initial begin
        int started = 0;
        int n;
        req_vld = '0; req_byte_vld = '0; req_byte_last = '0; req_dst_mac = '0;
        req_pkt_type = '0; req_byte = '0; m_byte_rdy = 1'b0; pkt_vld_mon = 1'b0;
        pkt_rdy_mon = 1'b0; tx_rst_n = 1'b0; b_last_bytes = 0;
        clear_models();
        rst_hold = 1'b1;
        repeat (3) step();
        rst_hold = 1'b0;
        repeat (2) step();

        // single requester, 10 bytes
        start_pkt(0, 10, 0, 0);
        wait_idle(300);

        // both requesters raised together, twice
        repeat (2) begin
            start_pkt(0, int'($urandom_range(4, 12)), 0, 0);
            start_pkt(1, int'($urandom_range(4, 12)), 0, 0);
            wait_idle(600);
        end

        // overlong stream, then exactly-max stream with last on the final byte
        start_pkt(1, PMAX + 1, 0, 0);
        wait_idle(4 * PMAX);
        start_pkt(0, PMAX, 0, 1);
        wait_idle(4 * PMAX);

        // gap after byte 5 of 20
        start_pkt(0, 20, 5, 0);
        wait_idle(400);

        // builder hand-off stalled 50 cycles while the other source waits
        b_hold_next = 50;
        start_pkt(0, 8, 0, 0);
        repeat (6) step();
        start_pkt(1, 8, 0, 2);
        wait_idle(600);

        // randomized traffic
        n = 0;
        while (started < 40 && n < 20000) begin
            for (int i = 0; i < N; i++) begin
                if (!r_active[i] && started < 40 && $urandom_range(0, 3) == 0) begin
                    int len = int'($urandom_range(1, 60));
                    int gap = (len > 1 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, len - 1)) : 0;
                    start_pkt(i, len, gap, int'($urandom_range(0, 4)));
                    started++;
                end
            end
            step();
            n++;
        end
        check(started == 40, "random_start", $sformatf("started %0d of 40", started));
        wait_idle(3000);

        // reset in the middle of a stream, then a fresh packet
        start_pkt(0, 20, 0, 0);
        n = 0;
        while (r_sent[0] < 3 && n < 200) begin
            step();
            n++;
        end
        check(n < 200, "stream_timeout", $sformatf("sent %0d bytes after %0d cycles", r_sent[0], n));
        clear_models();
        rst_hold = 1'b1;
        step();
        rst_hold = 1'b0;
        step();
        start_pkt(0, 12, 0, 0);
        wait_idle(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
